// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
// Pipelined WIDTH-bit adder/subtractor with carry/borrow-in. The carry chain
// is broken into CHUNK-bit ripple segments, one register stage per segment,
// so a result appears NSTAGE = WIDTH/CHUNK cycles after acceptance.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   A, B       WIDTH-bit operands
//   Cin        carry-in (Sub=0) or borrow-in (Sub=1)
//   Sub        0: A+B+Cin, 1: A-B-Cin
//   in_valid   operation presented
//   in_ready   block accepts this cycle (depends only on out_valid/out_ready)
//   Sum        low WIDTH bits of the result
//   Cout       carry out of the MSB (subtract: 1 = no borrow)
//   Ovf        two's-complement signed overflow
//   out_valid  Sum/Cout/Ovf hold a result
//   out_ready  downstream takes the result
module adder_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSTAGE = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

  // Reject configurations where the chunks do not tile the word exactly.
  if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("adder_pipe_nbit: WIDTH must be a positive multiple of CHUNK");
  end

  // Whole pipeline advances together; it only stalls on a held result.
  logic en_s;
  logic [WIDTH-1:0] be_s;
  logic             ci_s;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  assign en_s     = ~out_valid_r | out_ready;
  assign in_ready = en_s;

  // Subtract is folded in at capture: A - B - Cin == A + ~B + ~Cin.
  assign be_s = Sub ? ~B : B;
  assign ci_s = Sub ? ~Cin : Cin;

  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;
  assign out_valid = out_valid_r;

  // src_*_s[k] is what stage k works on: the raw inputs for stage 0, the
  // registers of stage k-1 otherwise. Upper operand chunks ride along
  // (skew delay) and finished low sum chunks are carried forward.
  logic [WIDTH-1:0] src_a_s   [NSTAGE];
  logic [WIDTH-1:0] src_be_s  [NSTAGE];
  logic [WIDTH-1:0] src_sum_s [NSTAGE];
  logic             src_c_s   [NSTAGE];
  logic             src_v_s   [NSTAGE];

  assign src_a_s[0]   = A;
  assign src_be_s[0]  = be_s;
  assign src_sum_s[0] = {WIDTH{1'b0}};
  assign src_c_s[0]   = ci_s;
  assign src_v_s[0]   = in_valid;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [CHUNK:0]   part_s;
    logic [WIDTH-1:0] sum_next_s;

    // Ripple-add this stage's chunk and merge it into the partial sum.
    always_comb begin
      part_s = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
             + {1'b0, src_be_s[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, src_c_s[k]};
      sum_next_s = src_sum_s[k];
      sum_next_s[k*CHUNK +: CHUNK] = part_s[CHUNK-1:0];
    end

    if (k < NSTAGE - 1) begin : g_mid
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] be_r;
      logic [WIDTH-1:0] psum_r;
      logic             c_r;
      logic             v_r;

      // Intermediate stage register: shifts on en, holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r    <= {WIDTH{1'b0}};
          be_r   <= {WIDTH{1'b0}};
          psum_r <= {WIDTH{1'b0}};
          c_r    <= 1'b0;
          v_r    <= 1'b0;
        end else if (en_s) begin
          a_r    <= src_a_s[k];
          be_r   <= src_be_s[k];
          psum_r <= sum_next_s;
          c_r    <= part_s[CHUNK];
          v_r    <= src_v_s[k];
        end
      end

      assign src_a_s[k+1]   = a_r;
      assign src_be_s[k+1]  = be_r;
      assign src_sum_s[k+1] = psum_r;
      assign src_c_s[k+1]   = c_r;
      assign src_v_s[k+1]   = v_r;
    end else begin : g_last
      // Final stage drives the output registers. The carry into the MSB is
      // recovered as a^b^s at that bit, so Ovf needs no extra carry tap.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_r       <= {WIDTH{1'b0}};
          cout_r      <= 1'b0;
          ovf_r       <= 1'b0;
          out_valid_r <= 1'b0;
        end else if (en_s) begin
          sum_r       <= sum_next_s;
          cout_r      <= part_s[CHUNK];
          ovf_r       <= src_a_s[k][WIDTH-1] ^ src_be_s[k][WIDTH-1]
                       ^ sum_next_s[WIDTH-1] ^ part_s[CHUNK];
          out_valid_r <= src_v_s[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
module tb_adder_pipe_nbit;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NS = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, in_valid, in_ready, out_ready, out_valid, cout, ovf;

  logic [3:0]   d_a, d_b, d_sum;
  logic         d_cin, d_sub, d_in_valid, d_in_ready, d_out_ready, d_out_valid, d_cout, d_ovf;

  adder_pipe_nbit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  adder_pipe_nbit #(.WIDTH(4), .CHUNK(4)) dut_deg (
    .clk(clk), .rst(rst), .A(d_a), .B(d_b), .Cin(d_cin), .Sub(d_sub),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .Sum(d_sum), .Cout(d_cout), .Ovf(d_ovf),
    .out_valid(d_out_valid), .out_ready(d_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
    int           stall_snap;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t r;
    int full, sres;
    if (s) begin
      full   = int'(x) - int'(y) - int'(ci);
      sres   = int'($signed(x)) - int'($signed(y)) - int'(ci);
      r.cout = (full >= 0);
    end else begin
      full   = int'(x) + int'(y) + int'(ci);
      sres   = int'($signed(x)) + int'($signed(y)) + int'(ci);
      r.cout = (full >= (1 << W));
    end
    r.sum        = full[W-1:0];
    r.ovf        = (sres > 32767) || (sres < -32768);
    r.acc_cyc    = 0;
    r.stall_snap = 0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.acc_cyc = 0; r.stall_snap = 0;
    return r;
  endfunction

  // Monitor: sampled on the falling edge, describing the coming rising edge.
  int           cyc = 0;
  int           stall_cnt = 0;
  logic         prev_rst = 1'b0;
  logic         seen_reset = 1'b0;
  logic         held = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout, held_ovf;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        check_eq("reset_valid", out_valid, 1'b0);
        check_eq("reset_sum", sum, 16'h0000);
        check_eq("reset_flags", {cout, ovf}, 2'b00);
      end
      if (rst) begin
        sb.delete();
        held = 1'b0;
      end else if (seen_reset) begin
        if (held) begin
          check_eq("hold_valid", out_valid, 1'b1);
          check_eq("hold_sum", sum, held_sum);
          check_eq("hold_flags", {cout, ovf}, {held_cout, held_ovf});
        end
        check_eq("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", out_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check_eq("sum", sum, e.sum);
            check_eq("cout", cout, e.cout);
            check_eq("ovf", ovf, e.ovf);
            check_eq("latency", cyc - e.acc_cyc, NS + stall_cnt - e.stall_snap);
          end
        end
        if (in_valid && in_ready) begin
          e = cur_exp;
          e.acc_cyc = cyc;
          e.stall_snap = stall_cnt;
          sb.push_back(e);
        end
        held      = out_valid && !out_ready;
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = ovf;
        if (out_valid && !out_ready) stall_cnt++;
      end
      prev_rst = rst;
      if (rst) seen_reset = 1'b1;
    end
  end

  // Present one op (called just after a rising edge); returns after acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s, input exp_t e);
    logic ok;
    ok = 1'b0;
    a = x; b = y; cin = ci; sub = s; cur_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_eq("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic send_rand();
    logic [W-1:0] x, y;
    logic ci, s;
    x = W'($urandom); y = W'($urandom);
    ci = 1'($urandom); s = 1'($urandom);
    send(x, y, ci, s, model(x, y, ci, s));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check_eq("drain_empty", sb.size(), 0);
  endtask

  logic rnd_done;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1234; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
    cur_exp = mk(16'h0000, 1'b0, 1'b0);
    d_a = 4'h0; d_b = 4'h0; d_cin = 1'b0; d_sub = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    rnd_done = 1'b0;

    // Reset held for two edges while an op is presented.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed arithmetic corners.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
    idle(6);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    send(16'h0005, 16'h0003, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    send(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    send(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0001, 1'b1, 1'b0));
    drain();

    // Eight back-to-back ops with a three-cycle downstream stall.
    fork
      begin
        repeat (8) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with bubbles and random backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) idle(1);
          else send_rand();
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: none of them may surface.
    repeat (3) send_rand();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(12);

    // Degenerate single-stage configuration: 9 + 7 + 1.
    d_a = 4'h9; d_b = 4'h7; d_cin = 1'b1; d_sub = 1'b0; d_in_valid = 1'b1;
    @(negedge clk);
    check_eq("deg_ready", d_in_ready, 1'b1);
    check_eq("deg_valid_before", d_out_valid, 1'b0);
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    @(negedge clk);
    check_eq("deg_valid_lat1", d_out_valid, 1'b1);
    check_eq("deg_sum", d_sum, 4'h1);
    check_eq("deg_cout", d_cout, 1'b1);
    check_eq("deg_ovf", d_ovf, 1'b0);
    @(negedge clk);
    check_eq("deg_valid_after", d_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
Parametrised, pipelined successor to the team's 4-bit full adder. It adds or subtracts two WIDTH-bit operands with carry/borrow-in. The carry chain is split into CHUNK-bit ripple stages, one register stage per chunk. Streaming valid/ready handshakes on both sides give one operation per cycle, with backpressure, for use in datapath and accumulator blocks.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits resolved per pipeline stage. WIDTH % CHUNK must be 0 and CHUNK ≥ 1; any other setting is an elaboration error.
- NSTAGE (localparam), WIDTH/CHUNK, pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (Sub=0) or borrow-in (Sub=1).
- Sub  in  1  0: A+B+Cin; 1: A−B−Cin.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept this cycle.
- Sum  out  WIDTH  result, low WIDTH bits.
- Cout  out  1  carry-out of the MSB (Sub=1: 1 = no borrow).
- Ovf  out  1  two's-complement signed overflow.
- out_valid  out  1  Sum/Cout/Ovf valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Arithmetic:
  - Effective operand Be = Sub ? ~B : B.
  - Effective carry-in ci = Sub ? ~Cin : Cin.
  - Result {Cout,Sum} = A + Be + ci, computed exactly mod 2^(WIDTH+1).
  - Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, in both modes.
- Pipeline:
  - Stage k (0..NSTAGE-1) adds bits [k*CHUNK +: CHUNK] of A and Be plus the carry registered from stage k-1. Stage 0 uses ci.
  - Upper operand chunks are skew-delayed; completed lower sum chunks are carried forward so that Sum is assembled aligned at the final stage.
  - Sub is applied at capture. No per-op state other than data, carry and a valid bit per stage.
- Handshake:
  - Global advance enable en = ~out_valid | out_ready.
  - in_ready = en, combinational from out_valid and out_ready only. It must not depend on in_valid.
  - An operation is accepted when in_valid & in_ready.
  - When en=1, every stage register and valid bit shifts by one. A bubble (in_valid=0) shifts in valid=0.
  - When en=0, all stages hold. Sum, Cout and Ovf stay stable while out_valid=1 and out_ready=0.
  - A result is consumed when out_valid & out_ready.
- Latency: exactly NSTAGE cycles from accept to out_valid, provided en stays 1. Each en=0 cycle adds one cycle.
- Throughput: 1 op/cycle when out_ready is held 1. Bubbles are not compressed.
- Ordering: results leave in acceptance order. No result is lost or duplicated.
- CHUNK == WIDTH: NSTAGE=1, a single registered adder with latency 1.
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear, out_valid=0, Sum=0, Cout=0, Ovf=0.
  - In-flight operations are discarded, including mid-operation.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset has priority over a simultaneous accept; the accepted op is dropped.
- Inputs are ignored when in_valid=0 or in_ready=0; X on idle inputs must not propagate to out_valid.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, Sum=0, Cout=0, Ovf=0; in_ready=1 after release; no result emerges from ops presented during reset.
- Basic add and latency (WIDTH=16, CHUNK=4): A=0x00FF, B=0x0001, Cin=0, Sub=0, out_ready=1 → out_valid exactly 4 cycles after accept, Sum=0x0100, Cout=0, Ovf=0.
- Full carry ripple and overflow:
  - 0xFFFF+0x0000+Cin=1 → Sum=0x0000, Cout=1, Ovf=0.
  - 0x7FFF+0x0001 → Sum=0x8000, Cout=0, Ovf=1.
- Subtract:
  - 5−3 → 0x0002, Cout=1.
  - 3−5 → 0xFFFE, Cout=0, Ovf=0.
  - 0x8000−1 → 0x7FFF, Ovf=1.
  - 5−3 with Cin=1 → 0x0001.
- Streaming and backpressure: 8 back-to-back random ops; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 for those cycles, outputs held stable, all 8 results correct, in order, no duplicates (checked against a reference model).
- Mid-operation reset and degenerate config:
  - rst with 3 ops in flight → out_valid=0 next cycle; no stale result emerges after reset.
  - WIDTH=4, CHUNK=4: 9+7+Cin=1 → Sum=0x1, Cout=1, latency 1.
